conv3x3_stream_engine: RTL

Parametrised successor to the fixed 8-bit, fixed-width 3x3 convolve controller. Consumes a three-row image stripe one column at a time over a valid/ready stream and holds a sliding 3x3 window. Performs a sequential 9-tap MAC against an internal kernel register file and emits one post-processed output pixel per window over a valid/ready stream. Supports stride 1/2, run-time row width, arithmetic output shift, optional ReLU and saturation.

---
 rtl/conv3x3_stream_engine.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/conv3x3_stream_engine.sv
// Streaming 3x3 convolution engine: column-fed sliding window, sequential 9-tap MAC,
// shift/ReLU/saturate post-processing, valid/ready on both sides.
module conv3x3_stream_engine #(
  parameter int DATA_W   = 8,
  parameter int KER_W    = 8,
  parameter int ACC_W    = 24,
  parameter int OUT_W    = 8,
  parameter int MAX_COLS = 32,
  parameter int COL_W    = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [1:0]              cfg_stride,
  input  logic [COL_W-1:0]        cfg_cols,
  input  logic [4:0]              cfg_shift,
  input  logic                    cfg_relu,
  input  logic                    k_wr_en,
  input  logic [3:0]              k_wr_addr,
  input  logic signed [KER_W-1:0] k_wr_data,
  input  logic                    col_valid,
  output logic                    col_ready,
  input  logic [3*DATA_W-1:0]     col_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_data,
  output logic                    out_last,
  output logic                    busy,
  output logic                    done,
  output logic                    err_cfg
);

  typedef enum logic [2:0] {IDLE, FILL, MAC, EMIT, DRAIN, DONE} state_t;

  localparam logic signed [ACC_W-1:0] OMAX = ACC_W'((1 << (OUT_W-1)) - 1);
  localparam logic signed [ACC_W-1:0] OMIN = ~OMAX;

  state_t                   state;
  logic [DATA_W-1:0]        win  [9];   // index = row*3 + col, col 2 is newest
  logic signed [KER_W-1:0]  kern [9];
  logic signed [ACC_W-1:0]  acc;
  logic [3:0]               tap;
  logic [1:0]               need, fill_cnt, stride_r;
  logic [COL_W-1:0]         cols_r, cols_in, n_out, out_cnt;
  logic [4:0]               shift_r;
  logic                     relu_r;

  logic signed [DATA_W+KER_W:0] mul;
  logic signed [ACC_W-1:0]      acc_next, shifted;
  logic signed [OUT_W-1:0]      sat;
  logic                         cfg_ok;
  logic [COL_W-1:0]             n_calc;

  always_comb begin
    mul      = $signed({1'b0, win[tap]}) * kern[tap];
    acc_next = acc + ACC_W'(mul);
    shifted  = acc_next >>> shift_r;
    if (relu_r && shifted[ACC_W-1]) shifted = '0;
    if (shifted > OMAX)      sat = OMAX[OUT_W-1:0];
    else if (shifted < OMIN) sat = OMIN[OUT_W-1:0];
    else                     sat = shifted[OUT_W-1:0];
    cfg_ok = (cfg_stride == 2'd1 || cfg_stride == 2'd2) &&
             cfg_cols >= COL_W'(3) && cfg_cols <= COL_W'(MAX_COLS);
    n_calc = (cfg_stride == 2'd2) ? ((cfg_cols - COL_W'(3)) >> 1) + COL_W'(1)
                                  : cfg_cols - COL_W'(2);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      for (int i = 0; i < 9; i++) begin
        win[i]  <= '0;
        kern[i] <= '0;
      end
      acc <= '0; tap <= '0; need <= '0; fill_cnt <= '0; stride_r <= '0;
      cols_r <= '0; cols_in <= '0; n_out <= '0; out_cnt <= '0;
      shift_r <= '0; relu_r <= 1'b0;
      col_ready <= 1'b0; out_valid <= 1'b0; out_data <= '0; out_last <= 1'b0;
      busy <= 1'b0; done <= 1'b0; err_cfg <= 1'b0;
    end else begin
      done    <= 1'b0;
      err_cfg <= 1'b0;
      case (state)
        IDLE: begin
          if (k_wr_en && k_wr_addr < 4'd9) kern[k_wr_addr] <= k_wr_data;
          if (start) begin
            if (cfg_ok) begin
              stride_r <= cfg_stride; cols_r <= cfg_cols; shift_r <= cfg_shift;
              relu_r <= cfg_relu; n_out <= n_calc;
              cols_in <= '0; out_cnt <= '0; fill_cnt <= '0; need <= 2'd3;
              col_ready <= 1'b1; busy <= 1'b1; state <= FILL;
            end else begin
              err_cfg <= 1'b1;
            end
          end
        end
        FILL: if (col_valid) begin
          for (int r = 0; r < 3; r++) begin
            win[r*3]   <= win[r*3+1];
            win[r*3+1] <= win[r*3+2];
            win[r*3+2] <= col_in[r*DATA_W +: DATA_W];
          end
          cols_in <= cols_in + COL_W'(1);
          if (fill_cnt == need - 2'd1) begin
            col_ready <= 1'b0; acc <= '0; tap <= '0; state <= MAC;
          end else begin
            fill_cnt <= fill_cnt + 2'd1;
          end
        end
        MAC: begin
          acc <= acc_next;
          tap <= tap + 4'd1;
          // last tap: the result includes this cycle's product
          if (tap == 4'd8) begin
            out_data  <= sat;
            out_valid <= 1'b1;
            out_last  <= (out_cnt == n_out - COL_W'(1));
            state     <= EMIT;
          end
        end
        EMIT: if (out_ready) begin
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          out_cnt   <= out_cnt + COL_W'(1);
          if (!out_last) begin
            need <= stride_r; fill_cnt <= '0; col_ready <= 1'b1; state <= FILL;
          end else if (cols_in < cols_r) begin
            col_ready <= 1'b1; state <= DRAIN;
          end else begin
            done <= 1'b1; state <= DONE;
          end
        end
        DRAIN: if (col_valid) begin
          cols_in <= cols_in + COL_W'(1);
          if (cols_in == cols_r - COL_W'(1)) begin
            col_ready <= 1'b0; done <= 1'b1; state <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
